// File: rtl/l0_cache_invalidate_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// l0_cache_invalidate_sequencer_pkg
// Shared types and default sizes for the L0 data-cache invalidate sequencer.
//   inv_seq_state_e : FSM encoding (IDLE, DRAIN, WALK, DONE)
//   INV_DEF_*       : default geometry used by the interface and the sequencer
// ---------------------------------------------------------------------------
package l0_cache_invalidate_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WALK  = 2'd2,
        DONE  = 2'd3
    } inv_seq_state_e;

    localparam int INV_DEF_INDEX_W     = 7;
    localparam int INV_DEF_TAG_W       = 7;
    localparam int INV_DEF_XLEN        = 32;
    localparam int INV_DEF_DRAIN_CYCLES = 2;

endpackage

// File: rtl/l0_cache_invalidate_sequencer_if.sv
// ---------------------------------------------------------------------------
// l0_cache_invalidate_sequencer_if
// Bundles the request/arbitration inputs and the cache write-port outputs of
// the invalidate sequencer.
//   i_inv_req          : single-cycle invalidate request pulse
//   i_write_port_busy  : another writer owns the cache write port this cycle
//   o_stall            : pipeline stall while an invalidate is in progress
//   o_inv_done         : one-cycle completion pulse
//   o_inv_write_*      : lowest-priority write request into the cache
// Modports: master = requester / l0_cache side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface l0_cache_invalidate_sequencer_if
    import l0_cache_invalidate_sequencer_pkg::*;
#(
    parameter int CacheIndexWidth = INV_DEF_INDEX_W,
    parameter int CacheTagWidth   = INV_DEF_TAG_W,
    parameter int XLEN            = INV_DEF_XLEN
) ();

    logic                       i_inv_req;
    logic                       i_write_port_busy;
    logic                       o_stall;
    logic                       o_inv_done;
    logic                       o_inv_write_enable;
    logic [CacheIndexWidth-1:0] o_inv_write_index;
    logic [CacheTagWidth-1:0]   o_inv_write_tag;
    logic [XLEN/8-1:0]          o_inv_write_valid;

    modport master (
        output i_inv_req,
        output i_write_port_busy,
        input  o_stall,
        input  o_inv_done,
        input  o_inv_write_enable,
        input  o_inv_write_index,
        input  o_inv_write_tag,
        input  o_inv_write_valid
    );

    modport slave (
        input  i_inv_req,
        input  i_write_port_busy,
        output o_stall,
        output o_inv_done,
        output o_inv_write_enable,
        output o_inv_write_index,
        output o_inv_write_tag,
        output o_inv_write_valid
    );

endinterface

// File: rtl/l0_cache_invalidate_sequencer.sv
// ---------------------------------------------------------------------------
// l0_cache_invalidate_sequencer
// Walks every L0 data-cache index once, issuing one valid-clearing write per
// free write-port cycle, while stalling the pipeline. Existing writers always
// win the port: a busy cycle holds the walk index and issues nothing.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   bus    : slave side of l0_cache_invalidate_sequencer_if (request, busy,
//            stall, done pulse and the invalidate write request)
// ---------------------------------------------------------------------------
module l0_cache_invalidate_sequencer
    import l0_cache_invalidate_sequencer_pkg::*;
#(
    parameter int CacheIndexWidth = INV_DEF_INDEX_W,
    parameter int CacheTagWidth   = INV_DEF_TAG_W,
    parameter int XLEN            = INV_DEF_XLEN,
    parameter int DrainCycles     = INV_DEF_DRAIN_CYCLES
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    l0_cache_invalidate_sequencer_if.slave bus
);

    localparam int DrainW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
    localparam logic [DrainW-1:0]          DRAIN_LAST = DrainW'(DrainCycles - 1);
    localparam logic [CacheIndexWidth-1:0] IDX_LAST   = '1;

    inv_seq_state_e             state_q, state_d;
    logic [CacheIndexWidth-1:0] idx_q, idx_d;
    logic [DrainW-1:0]          drain_cnt_q, drain_cnt_d;
    logic                       pending_q, pending_d;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_cnt_q <= drain_cnt_d;
            pending_q   <= pending_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_cnt_d = drain_cnt_q;
        pending_d   = pending_q;

        // Any request that arrives while busy coalesces into one re-walk.
        if (bus.i_inv_req && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.i_inv_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                // Needs DrainCycles consecutive idle cycles so a registered
                // load fill cannot land after an index has been cleared.
                if (bus.i_write_port_busy) begin
                    drain_cnt_d = '0;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = WALK;
                    idx_d       = '0;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            WALK: begin
                if (!bus.i_write_port_busy) begin
                    idx_d = idx_q + 1'b1;  // wraps to 0 after the last index
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A request in this very cycle counts as pending too.
                pending_d   = 1'b0;
                drain_cnt_d = '0;
                state_d     = (pending_q || bus.i_inv_req) ? DRAIN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: stall and done depend on state only; everything is forced
    // low while reset is asserted.
    always_comb begin
        bus.o_stall            = 1'b0;
        bus.o_inv_done         = 1'b0;
        bus.o_inv_write_enable = 1'b0;
        bus.o_inv_write_index  = '0;
        bus.o_inv_write_tag    = {CacheTagWidth{1'b0}};
        bus.o_inv_write_valid  = {(XLEN/8){1'b0}};
        if (!i_rst) begin
            bus.o_stall    = (state_q != IDLE);
            bus.o_inv_done = (state_q == DONE);
            if (state_q == WALK) begin
                bus.o_inv_write_enable = ~bus.i_write_port_busy;
                bus.o_inv_write_index  = idx_q;
            end
        end
    end

endmodule
